pipemdu: RTL and testbench
==========================

# pipemdu

Iterative multiply/divide unit with HI/LO registers for the five-stage pipelined CPU. It sits beside the ALU in the EXE stage. It accepts mult/multu/div/divu operands from the ID/EXE pipeline register and computes the result over multiple cycles. While it computes, it raises `busy`, which the ID-stage hazard logic ORs into the stall term that drives `wpcir` and `dbubble`.

## Interface
Parameters:
- `ITER`, 32: iteration count. Equals the operand width; must not be changed.

Ports:
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  EXE-stage instruction is mult/multu/div/divu; sampled only in IDLE.
- `op`  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- `a`  in  32  rs operand (dividend / multiplicand).
- `b`  in  32  rt operand (divisor / multiplier).
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  32  mthi/mtlo data.
- `busy`  out  1  unit is computing; the pipeline must stall mfhi/mflo/start/mthi/mtlo.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- `dz`  out  1  last division had a zero divisor; sticky until the next accepted `start`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE & `start` → CALC. Latches `op`, |a|, |b| (magnitudes for signed ops), and the result sign bits. Clears the 5-bit iteration counter. Clears `dz`.
  - CALC: one iteration per edge. The counter increments; after iteration `ITER-1` the FSM goes to FIX.
  - FIX: applies the sign correction, writes HI/LO, pulses `done`, and returns to IDLE.
- Multiply: radix-2 shift-add on a 64-bit {acc, multiplier} register. If the product sign is negative, the 64-bit two's complement is taken. HI receives [63:32] and LO receives [31:0].
- Divide: restoring division, one 33-bit trial subtract per iteration.
  - LO receives the quotient and HI receives the remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0. This is the natural wrap; no trap is raised.
- Divide by zero (`b`==0 on a div/divu start): skip CALC and go IDLE→FIX directly. FIX writes HI=`a` (unmodified), LO=0xFFFFFFFF, and sets `dz`.
- mthi/mtlo in IDLE with `start` low: the register is written at the next edge. Both may be asserted in the same cycle.
- Simultaneous `start` and mthi/mtlo in IDLE: `start` wins and mthi/mtlo are dropped.
- `start`, mthi, and mtlo while `busy`: ignored. The hazard unit guarantees they do not occur; the bench checks that ignoring them is harmless.
- `busy` = (state != IDLE). It is a registered state decode and contains no combinational input path.

## Timing
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, dz=0, counter=0.
- Reset mid-operation: asynchronous return to reset values; the partial result is discarded.
- Normal op latency:
  - `start` is sampled at edge E0, and `busy` is high from E0 to E33 (33 cycles).
  - CALC covers edges E1..E32.
  - FIX writes HI/LO at E33; `done` is high for the cycle after E33.
- Divide by zero: FIX at E1 writes HI/LO; `busy` is high for 1 cycle and `done` follows E1.
- A back-to-back `start` is accepted at E34 at the earliest (first IDLE cycle). The same-cycle `done` and new `start` is legal.
- `hi`/`lo` are updated only at FIX edges or mthi/mtlo edges. They hold their values during CALC.

## Structure
- Shared package `pipemdu_pkg`:
  - op encodings `OP_MULT/OP_MULTU/OP_DIV/OP_DIVU`;
  - state enum IDLE/CALC/FIX;
  - `ITER`=32 and counter width 5.
- Sub-module `mdu_step`: combinational single iteration. It takes mode, the 64-bit working register, and the 32-bit operand, and returns the next working register: shift-add for multiply, trial-subtract-shift for divide.
- The top level holds the FSM, counter, operand/sign latches, the sign-fix negation, and the HI/LO registers.

## Test plan
- mult a=0xFFFFFFFD (-3), b=5 → E33: HI=0xFFFFFFFF, LO=0xFFFFFFF1; `busy` high 33 cycles, `done` 1 cycle.
- multu a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu 100/7 → LO=14, HI=2.
- divu a=100, b=0 → after E1: HI=100, LO=0xFFFFFFFF, `dz`=1; the next mult start clears `dz`.
- mtlo 0x1234 in IDLE → LO=0x1234 next edge. mthi asserted during CALC → HI unchanged at FIX; the result is correct.
- Reset asserted at iteration 10 of a div → immediately busy=0, hi=lo=0. A new start after reset release completes correctly.

Source files
------------

// File: rtl/pipemdu_pkg.sv
// -----------------------------------------------------------------------------
// pipemdu_pkg
//   Shared definitions for the iterative multiply/divide unit: operation
//   encodings, FSM state type, iteration count and the small helpers that
//   classify an operation and take operand magnitudes.
// -----------------------------------------------------------------------------
package pipemdu_pkg;

    localparam int ITER  = 32;  // one iteration per operand bit
    localparam int CNT_W = 5;   // wide enough to count 0..ITER-1

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Bit 1 of the encoding selects divide, bit 0 selects unsigned.
    function automatic logic is_div(input op_t op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input op_t op);
        return ~op[0];
    endfunction

    // Absolute value for signed operations, passthrough for unsigned ones.
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/pipemdu_if.sv
// -----------------------------------------------------------------------------
// pipemdu_if
//   Operand/result bundle between the EXE stage and the multiply/divide unit.
//   master: pipeline side (drives start/op/operands/mthi/mtlo/wdata)
//   slave : the unit (drives busy/done/dz/hi/lo)
// -----------------------------------------------------------------------------
interface pipemdu_if;
    import pipemdu_pkg::*;

    logic        start;  // EXE instruction is mult/multu/div/divu
    op_t         op;     // operation select
    logic [31:0] a;      // rs: dividend / multiplicand
    logic [31:0] b;      // rt: divisor / multiplier
    logic        mthi;   // write wdata to HI
    logic        mtlo;   // write wdata to LO
    logic [31:0] wdata;  // mthi/mtlo data
    logic        busy;   // unit computing, pipeline must stall
    logic        done;   // one-cycle pulse after HI/LO written by an operation
    logic        dz;     // sticky divide-by-zero flag
    logic [31:0] hi;     // HI register
    logic [31:0] lo;     // LO register

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, dz, hi, lo
    );

endinterface

// File: rtl/pipemdu_step.sv
// -----------------------------------------------------------------------------
// mdu_step
//   One combinational iteration of the multiply/divide datapath.
//   mode     : operation (only the multiply/divide distinction matters here)
//   work_in  : 64-bit working register
//   operand  : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   work_out : working register after this iteration
//
//   Multiply: work = {acc, multiplier}. If the multiplier LSB is set, add the
//   operand to acc; then shift the whole {carry, acc, multiplier} right by one.
//   Divide:   work = {remainder, dividend/quotient}. Shift left by one, try
//   subtracting the divisor from the upper 33 bits, keep the difference and
//   shift in a 1 when it does not borrow, otherwise shift in a 0.
// -----------------------------------------------------------------------------
module mdu_step
    import pipemdu_pkg::*;
(
    input  op_t         mode,
    input  logic [63:0] work_in,
    input  logic [31:0] operand,
    output logic [63:0] work_out
);

    logic [32:0] add_sum;
    logic [33:0] trial;

    // NOTE: every output of a combinational block gets a value on every path
    // (here by computing unconditionally and selecting), so no latch appears.
    always_comb begin
        add_sum = {1'b0, work_in[63:32]} + (work_in[0] ? {1'b0, operand} : 33'd0);
        // Remainder stays below the divisor, so the shifted partial remainder
        // fits in 33 bits; the extra MSB of trial is the borrow.
        trial   = {1'b0, work_in[63:31]} - {2'b00, operand};

        if (is_div(mode)) begin
            if (trial[33]) begin
                work_out = {work_in[62:0], 1'b0};
            end else begin
                work_out = {trial[31:0], work_in[30:0], 1'b1};
            end
        end else begin
            work_out = {add_sum, work_in[31:1]};
        end
    end

endmodule

// File: rtl/pipemdu.sv
// -----------------------------------------------------------------------------
// pipemdu
//   Iterative multiply/divide unit with HI/LO registers for the EXE stage.
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : pipemdu_if.slave (start/op/a/b/mthi/mtlo/wdata in,
//           busy/done/dz/hi/lo out)
//
//   IDLE --start--> CALC (ITER iterations) --> FIX --> IDLE
//   IDLE --start, divide by zero--> FIX --> IDLE
//   Operands are reduced to magnitudes on entry; FIX restores the signs and
//   writes HI/LO. busy is a pure decode of the state register.
// -----------------------------------------------------------------------------
module pipemdu #(
    parameter int ITER = pipemdu_pkg::ITER  // equals the operand width; fixed
) (
    input  logic      clock,
    input  logic      reset,
    pipemdu_if.slave  bus
);
    import pipemdu_pkg::*;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    op_t               op_q;
    logic [31:0]       opnd_q;      // operand fed to every iteration
    logic [63:0]       work_q;      // {acc, multiplier} or {remainder, quotient}
    logic              neg_q;       // product or quotient must be negated
    logic              rem_neg_q;   // remainder must be negated (dividend sign)
    logic              zdiv_q;      // current operation is a divide by zero
    logic              done_q;
    logic              dz_q;
    logic [31:0]       hi_q, lo_q;

    logic              sgn_in;
    logic [31:0]       a_mag, b_mag;
    logic              zero_div;
    logic              last_iter;
    logic [63:0]       work_step;
    logic [63:0]       prod_fix;
    logic [31:0]       quo_fix, rem_fix;

    // ------------------------------------------------------------------------
    // Operand conditioning and sign correction
    // ------------------------------------------------------------------------
    assign sgn_in    = is_signed_op(bus.op);
    assign a_mag     = magnitude(bus.a, sgn_in);
    assign b_mag     = magnitude(bus.b, sgn_in);
    assign zero_div  = is_div(bus.op) && (bus.b == 32'd0);
    assign last_iter = (cnt_q == CNT_W'(ITER - 1));

    assign prod_fix  = neg_q     ? (~work_q + 64'd1)         : work_q;
    assign quo_fix   = neg_q     ? (~work_q[31:0] + 32'd1)   : work_q[31:0];
    assign rem_fix   = rem_neg_q ? (~work_q[63:32] + 32'd1)  : work_q[63:32];

    mdu_step u_step (
        .mode     (op_q),
        .work_in  (work_q),
        .operand  (opnd_q),
        .work_out (work_step)
    );

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = zero_div ? FIX : CALC;
            CALC:    if (last_iter) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath, HI/LO and status flags
    // ------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of the others, independent of statement order.
    // NOTE: HI/LO are architectural registers with defined reset values, so
    // they are reset along with the control state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            opnd_q    <= '0;
            work_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            zdiv_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= (state_q == FIX);

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // start wins over a simultaneous mthi/mtlo
                        op_q   <= bus.op;
                        cnt_q  <= '0;
                        dz_q   <= 1'b0;
                        zdiv_q <= zero_div;
                        if (is_div(bus.op)) begin
                            opnd_q    <= b_mag;
                            // Divide by zero reports the raw dividend in HI,
                            // so park it where FIX reads it.
                            work_q    <= zero_div ? {bus.a, 32'd0} : {32'd0, a_mag};
                            neg_q     <= sgn_in & (bus.a[31] ^ bus.b[31]);
                            rem_neg_q <= sgn_in & bus.a[31];
                        end else begin
                            opnd_q    <= a_mag;
                            work_q    <= {32'd0, b_mag};
                            neg_q     <= sgn_in & (bus.a[31] ^ bus.b[31]);
                            rem_neg_q <= 1'b0;
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end

                CALC: begin
                    work_q <= work_step;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end

                FIX: begin
                    if (zdiv_q) begin
                        hi_q <= work_q[63:32];
                        lo_q <= 32'hFFFF_FFFF;
                        dz_q <= 1'b1;
                    end else if (is_div(op_q)) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                end

                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_pipemdu.sv
// -----------------------------------------------------------------------------
// tb_pipemdu
//   Self-checking bench for pipemdu. Expected HI/LO come from plain 64-bit
//   integer arithmetic; expected timing from the cycle counts of the unit.
// -----------------------------------------------------------------------------
module tb_pipemdu;
    import pipemdu_pkg::*;

    logic clock = 1'b0;
    logic reset;

    pipemdu_if bus ();

    pipemdu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] hi_ref = 32'd0;
    logic [31:0] lo_ref = 32'd0;
    logic        dz_ref = 1'b0;

    // Reference: {HI, LO} for an operation, from ordinary integer arithmetic.
    function automatic logic [63:0] ref_result(input op_t op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 31)) - 32'd16;
            4:       return 32'($urandom_range(1, 1000));
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = 32'd0;
    endtask

    // Issue one operation, follow it to completion and check timing, HI/LO
    // hold during the computation, and the final result. with_mt asserts
    // mthi/mtlo together with start; poke drives start/mthi/mtlo while busy.
    task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                          input string name, input bit with_mt, input bit poke, input bit check_pulse);
        logic [63:0] exp;
        int          lat;
        int          k;
        int          k_done;
        exp    = ref_result(op, a, b);
        lat    = (is_div(op) && b == 32'd0) ? 1 : 33;
        k_done = 0;

        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (with_mt) begin
            bus.mthi  = 1'b1;
            bus.mtlo  = 1'b1;
            bus.wdata = $urandom;
        end
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;

        n_vec++;
        if ({bus.busy, bus.done, bus.dz, bus.hi, bus.lo} !== {1'b1, 1'b0, 1'b0, hi_ref, lo_ref}) begin
            n_err++;
            $display("FAIL %s accept: busy/done/dz/hi/lo=%b/%b/%b/%h/%h want 1/0/0/%h/%h",
                     name, bus.busy, bus.done, bus.dz, bus.hi, bus.lo, hi_ref, lo_ref);
        end

        k = 1;
        while (k <= 40 && k_done == 0) begin
            if (poke && lat > 1 && k >= 3 && k <= 6) begin
                bus.start = 1'b1;
                bus.op    = op_t'($urandom_range(0, 3));
                bus.mthi  = 1'b1;
                bus.mtlo  = 1'b1;
                bus.wdata = $urandom;
            end else begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
            end
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) begin
                k_done = k;
            end else begin
                n_vec++;
                if (bus.busy !== 1'b1 || bus.hi !== hi_ref || bus.lo !== lo_ref) begin
                    n_err++;
                    $display("FAIL %s hold@%0d: busy/hi/lo=%b/%h/%h want 1/%h/%h",
                             name, k, bus.busy, bus.hi, bus.lo, hi_ref, lo_ref);
                end
            end
            k++;
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;

        n_vec++;
        if (k_done != lat) begin
            n_err++;
            $display("FAIL %s latency: done after %0d edges want %0d", name, k_done, lat);
        end

        n_vec++;
        if ({bus.busy, bus.hi, bus.lo, bus.dz} !== {1'b0, exp, (lat == 1)}) begin
            n_err++;
            $display("FAIL %s result: busy/hi/lo/dz=%b/%h/%h/%b want 0/%h/%h/%b",
                     name, bus.busy, bus.hi, bus.lo, bus.dz, exp[63:32], exp[31:0], (lat == 1));
        end
        hi_ref = exp[63:32];
        lo_ref = exp[31:0];
        dz_ref = (lat == 1);

        if (check_pulse) begin
            @(posedge clock);
            #1;
            n_vec++;
            if ({bus.done, bus.busy} !== 2'b00) begin
                n_err++;
                $display("FAIL %s pulse: done/busy=%b/%b want 0/0", name, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.dz, bus.hi, bus.lo} !== {3'b000, 64'd0}) begin
            n_err++;
            $display("FAIL reset: busy/done/dz/hi/lo=%b/%b/%b/%h/%h want 0/0/0/0/0",
                     bus.busy, bus.done, bus.dz, bus.hi, bus.lo);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.dz, bus.hi, bus.lo} !== {3'b000, 64'd0}) begin
            n_err++;
            $display("FAIL reset_release: busy/done/dz/hi/lo=%b/%b/%b/%h/%h want 0/0/0/0/0",
                     bus.busy, bus.done, bus.dz, bus.hi, bus.lo);
        end
    endtask

    task automatic test_directed();
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,        "mult_neg3x5",   1'b0, 1'b0, 1'b1);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max",    1'b0, 1'b0, 1'b1);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        "div_neg7by2",   1'b0, 1'b0, 1'b1);
        run_op(OP_DIVU,  32'd100,       32'd7,        "divu_100by7",   1'b0, 1'b0, 1'b1);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_minby_m1", 1'b0, 1'b0, 1'b1);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, "div_7by_m2",   1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_div_zero();
        run_op(OP_DIVU, 32'd100, 32'd0, "divu_by_zero", 1'b0, 1'b0, 1'b1);
        // dz stays set across an mthi in IDLE
        @(negedge clock);
        bus.mthi  = 1'b1;
        bus.wdata = 32'hCAFE_0001;
        @(posedge clock);
        #1;
        bus.mthi = 1'b0;
        hi_ref   = 32'hCAFE_0001;
        n_vec++;
        if ({bus.dz, bus.hi, bus.lo} !== {dz_ref, hi_ref, lo_ref}) begin
            n_err++;
            $display("FAIL dz_sticky: dz/hi/lo=%b/%h/%h want %b/%h/%h",
                     bus.dz, bus.hi, bus.lo, dz_ref, hi_ref, lo_ref);
        end
        // next start clears dz (checked at the accept edge inside run_op)
        run_op(OP_MULT, 32'd6, 32'hFFFF_FFF9, "mult_after_dz", 1'b0, 1'b0, 1'b1);
        run_op(OP_DIV, 32'h8000_0000, 32'd0, "div_min_by_zero", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clock);
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h0000_1234;
        @(posedge clock);
        #1;
        bus.mtlo = 1'b0;
        lo_ref   = 32'h0000_1234;
        n_vec++;
        if ({bus.hi, bus.lo} !== {hi_ref, lo_ref}) begin
            n_err++;
            $display("FAIL mtlo: hi/lo=%h/%h want %h/%h", bus.hi, bus.lo, hi_ref, lo_ref);
        end

        @(negedge clock);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h5A5A_A5A5;
        @(posedge clock);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        hi_ref   = 32'h5A5A_A5A5;
        lo_ref   = 32'h5A5A_A5A5;
        n_vec++;
        if ({bus.hi, bus.lo} !== {hi_ref, lo_ref}) begin
            n_err++;
            $display("FAIL mthi_mtlo: hi/lo=%h/%h want %h/%h", bus.hi, bus.lo, hi_ref, lo_ref);
        end

        // start together with mthi/mtlo: the writes are dropped
        run_op(OP_MULTU, 32'd123456, 32'd789, "start_with_mt", 1'b1, 1'b0, 1'b1);
        // mthi/mtlo/start while busy are ignored
        run_op(OP_DIV, 32'hFFFF_8000, 32'd37, "poke_while_busy", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, "b2b_0", 1'b0, 1'b0, 1'b0);
        run_op(OP_DIVU,  32'hFFFF_FFFF, 32'd3,         "b2b_1", 1'b0, 1'b0, 1'b0);
        run_op(OP_DIVU,  32'd5,         32'd0,         "b2b_2", 1'b0, 1'b0, 1'b0);
        run_op(OP_MULT,  32'h8000_0000, 32'hFFFF_FFFF, "b2b_3", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'd13;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        hi_ref = 32'd0;
        lo_ref = 32'd0;
        dz_ref = 1'b0;
        n_vec++;
        if ({bus.busy, bus.done, bus.dz, bus.hi, bus.lo} !== {3'b000, 64'd0}) begin
            n_err++;
            $display("FAIL reset_mid_op: busy/done/dz/hi/lo=%b/%b/%b/%h/%h want 0/0/0/0/0",
                     bus.busy, bus.done, bus.dz, bus.hi, bus.lo);
        end
        @(negedge clock);
        reset = 1'b0;
        run_op(OP_DIV, 32'hFFFF_FF00, 32'd9, "after_reset", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 48; i++) begin
            op = op_t'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, $sformatf("rand%0d", i), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
